mem_sum_engine: RTL and testbench
=================================

Name: mem_sum_engine

Overview:
- Datapath-plus-FSM block that sums a contiguous run of words from a synchronous-read memory.
- Acts as the reader/initiator on the memory side.
- Drives the load-enables of its internal accumulator, index and argument registers.
- Sits between a host issuing start/base/count and a single-port RAM. It returns the sum, a sticky overflow flag and a done level.

Parameters:
WIDTH, 32, data and accumulator width in bits
AW, 8, memory address width; also the width of count

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
base_addr  input  AW  first word address, captured when start is accepted
count  input  AW  number of words to sum, captured when start is accepted; 0 is legal
mem_addr  output  AW  read address; valid when mem_re=1
mem_re  output  1  read strobe; one-cycle pulse per word
mem_rdata  input  WIDTH  read data; valid exactly one cycle after mem_re
sum  output  WIDTH  accumulator value; final result is valid while done=1
overflow  output  1  sticky; set if any accumulation carried out of WIDTH bits
busy  output  1  high in every state except IDLE and DONE
done  output  1  high only in DONE

Behaviour:
- Reset (rst=1 at edge), from any state including mid-run:
  - state -> IDLE.
  - sum=0, overflow=0, mem_addr=0, mem_re=0, busy=0, done=0; internal index and captured args = 0.
- States: IDLE, INIT, TEST, WAIT, ACC, DONE. Moore outputs, decoded from state only.
- IDLE:
  - start=1 -> capture base_addr/count into registers (load-enable high for one cycle) -> INIT.
  - Otherwise stay in IDLE.
- INIT: sum<=0, idx<=0, overflow<=0 -> TEST.
- TEST:
  - idx==count_r -> DONE.
  - Else mem_re=1, mem_addr=base_r+idx (mod 2^AW; wraps 0xFF->0x00 at AW=8) -> WAIT.
- WAIT: no register updates; memory presents data -> ACC.
- ACC: {carry,sum}<=sum+mem_rdata; overflow<=overflow|carry; idx<=idx+1 -> TEST.
  - Sum wraps modulo 2^WIDTH.
- DONE:
  - done=1; sum and overflow frozen.
  - start=0 -> IDLE; start still 1 -> stay in DONE. No auto-restart on a held start.
- Timing, with start sampled in IDLE at edge 0:
  - INIT is cycle 1 and the first TEST is cycle 2.
  - Each word costs 3 cycles (TEST, WAIT, ACC).
  - done rises in cycle 3+3N. For N=0 that is cycle 3, with sum=0.
- start while busy or in DONE never recaptures arguments. base_addr/count changes after capture are ignored.
- sum is visible during accumulation (running partial). Consumers use it only when done=1.
- idx and count are AW bits wide, so the maximum run is 2^AW-1 words.

Decomposition:
- Shared package holds:
  - State encoding localparams: S_IDLE=0, S_INIT=1, S_TEST=2, S_WAIT=3, S_ACC=4, S_DONE=5, on a 3-bit state.
  - Default WIDTH/AW constants.
- Sub-module mem_sum_ctrl: pure FSM.
  - Inputs: start, idx_eq_count.
  - Outputs: ld_args, clr, ld_acc, inc_idx, mem_re, busy, done.
- The top level holds the datapath registers, adder and address adder, driven by those control strobes.

Test Plan:
- Basic sum:
  - Stimulus: mem[0x10..0x13]={1,2,3,4}, base=0x10, count=4, start pulse.
  - Response: mem_re pulses at 0x10,0x11,0x12,0x13 three cycles apart; done rises at cycle 15; sum=10; overflow=0.
- Zero count: count=0, start.
  - No mem_re pulses.
  - done at cycle 3; sum=0.
- Overflow and address wrap:
  - Stimulus: base=0xFE, count=3, mem[0xFE]=0xFFFFFFFF, mem[0xFF]=2, mem[0x00]=5.
  - Response: addresses 0xFE,0xFF,0x00; sum=6; overflow=1.
- Reset mid-run:
  - Stimulus: start a count=4 run; rst=1 at cycle 7.
  - Response: next cycle is IDLE, sum=0, busy=0, mem_re=0.
  - A subsequent fresh run produces a correct result.
- Held start and ignored re-start:
  - start held high through the whole run; base_addr/count changed while busy.
  - Original arguments are used.
  - FSM stays in DONE until start drops, then returns to IDLE.
  - Overflow from the previous run is cleared in INIT of the next run.

Source files
------------

// File: rtl/mem_sum_pkg.sv
// Shared types and constants for the memory-run summing engine.
// Holds the FSM state encoding, default widths and the per-state control decode.
package mem_sum_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int AW_DEF    = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_TEST = 3'd2,
    S_WAIT = 3'd3,
    S_ACC  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  typedef struct packed {
    logic clr;
    logic ld_acc;
    logic inc_idx;
    logic busy;
    logic done;
  } ctrl_flags_t;

  // Moore strobes as a pure function of state, so they can be registered with the state
  function automatic ctrl_flags_t decode_state(input state_t st);
    ctrl_flags_t f;
    f = '0;
    case (st)
      S_IDLE: f = '0;
      S_INIT: begin f.clr = 1'b1; f.busy = 1'b1; end
      S_TEST: f.busy = 1'b1;
      S_WAIT: f.busy = 1'b1;
      S_ACC:  begin f.ld_acc = 1'b1; f.inc_idx = 1'b1; f.busy = 1'b1; end
      S_DONE: f.done = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mem_sum_ctrl.sv
// Control FSM for mem_sum_engine: sequences INIT/TEST/WAIT/ACC per word.
// Strobes are registered alongside the state; mem_re and ld_args also depend on live inputs.
module mem_sum_ctrl
  import mem_sum_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic idx_eq_count,
  output logic ld_args,
  output logic clr,
  output logic ld_acc,
  output logic inc_idx,
  output logic mem_re,
  output logic busy,
  output logic done
);

  state_t      state_r;
  ctrl_flags_t flags_r;

  function automatic state_t next_state(input state_t st, input logic go, input logic eq);
    state_t n;
    n = st;
    case (st)
      S_IDLE: n = go ? S_INIT : S_IDLE;
      S_INIT: n = S_TEST;
      S_TEST: n = eq ? S_DONE : S_WAIT;
      S_WAIT: n = S_ACC;
      S_ACC:  n = S_TEST;
      S_DONE: n = go ? S_DONE : S_IDLE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  // State register with strobes decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      flags_r <= decode_state(S_IDLE);
    end else begin
      state_r <= next_state(state_r, start, idx_eq_count);
      flags_r <= decode_state(next_state(state_r, start, idx_eq_count));
    end
  end

  // TEST with idx==count heads straight to DONE, so no read is issued there
  assign mem_re  = (state_r == S_TEST) && !idx_eq_count;
  assign ld_args = (state_r == S_IDLE) && start;
  assign clr     = flags_r.clr;
  assign ld_acc  = flags_r.ld_acc;
  assign inc_idx = flags_r.inc_idx;
  assign busy    = flags_r.busy;
  assign done    = flags_r.done;

endmodule

// File: rtl/mem_sum_engine.sv
// Sums a contiguous run of words read from a synchronous-read RAM.
// Datapath registers and adders live here; sequencing comes from mem_sum_ctrl.
module mem_sum_engine
  import mem_sum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW-1:0]    count,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_re,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  logic [AW-1:0]    base_r;
  logic [AW-1:0]    count_r;
  logic [AW-1:0]    idx_r;
  logic [WIDTH-1:0] sum_r;
  logic             overflow_r;
  logic [WIDTH:0]   add_s;
  logic             idx_eq_count_s;
  logic             ld_args_s;
  logic             clr_s;
  logic             ld_acc_s;
  logic             inc_idx_s;

  mem_sum_ctrl u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .idx_eq_count (idx_eq_count_s),
    .ld_args      (ld_args_s),
    .clr          (clr_s),
    .ld_acc       (ld_acc_s),
    .inc_idx      (inc_idx_s),
    .mem_re       (mem_re),
    .busy         (busy),
    .done         (done)
  );

  assign idx_eq_count_s = (idx_r == count_r);
  assign add_s          = {1'b0, sum_r} + {1'b0, mem_rdata};
  // Address arithmetic is AW bits wide, so runs wrap around the top of memory
  assign mem_addr       = base_r + idx_r;

  // Datapath registers driven by the control strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r     <= '0;
      count_r    <= '0;
      idx_r      <= '0;
      sum_r      <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (ld_args_s) begin
        base_r  <= base_addr;
        count_r <= count;
      end
      if (clr_s) begin
        idx_r      <= '0;
        sum_r      <= '0;
        overflow_r <= 1'b0;
      end else if (ld_acc_s) begin
        sum_r      <= add_s[WIDTH-1:0];
        overflow_r <= overflow_r | add_s[WIDTH];
      end
      if (inc_idx_s && !clr_s) begin
        idx_r <= idx_r + AW'(1);
      end
    end
  end

  assign sum      = sum_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_mem_sum_engine.sv
// Directed bench for mem_sum_engine with a RAM model and a read-address scoreboard.
module tb_mem_sum_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  count;
  logic [7:0]  mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic [31:0] sum;
  logic        overflow;
  logic        busy;
  logic        done;

  logic [31:0] mem [256];
  logic [7:0]  exp_q [$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_re_cyc = 0;
  bit          first_re = 1'b1;

  mem_sum_engine #(.WIDTH(32), .AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .sum       (sum),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read RAM: output register holds until the next read
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every read strobe must match the next expected address, 3 cycles apart
  always @(negedge clk) begin
    if (mem_re === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_re", {24'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        check("mem_addr", {24'd0, mem_addr}, {24'd0, exp_q.pop_front()});
        if (!first_re) check("re_spacing", last_re_cyc == 0 ? 32'd0 : cyc - last_re_cyc, 32'd3);
      end
      first_re    = 1'b0;
      last_re_cyc = cyc;
    end
  end

  task automatic launch(input logic [7:0] b, input logic [7:0] n);
    logic [7:0] a;
    @(negedge clk);
    base_addr = b;
    count     = n;
    start     = 1'b1;
    first_re  = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = b + 8'(i);
      exp_q.push_back(a);
    end
    @(posedge clk);
  endtask

  task automatic do_run(input logic [7:0] b, input logic [7:0] n, input logic [31:0] esum,
                        input logic eov, input bit hold);
    int c;
    launch(b, n);
    c = 1;
    @(negedge clk);
    if (hold) begin
      base_addr = ~b;
      count     = n + 8'd3;
    end else begin
      start = 1'b0;
    end
    while (done !== 1'b1 && c < 200) begin
      @(posedge clk);
      c++;
      @(negedge clk);
    end
    check("done_cycle", c, 3 + 3 * n);
    check("sum", sum, esum);
    check("overflow", {31'd0, overflow}, {31'd0, eov});
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("reads_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h10] = 32'd1; mem[8'h11] = 32'd2; mem[8'h12] = 32'd3; mem[8'h13] = 32'd4;
    mem[8'hFE] = 32'hFFFF_FFFF; mem[8'hFF] = 32'd2; mem[8'h00] = 32'd5;
    mem[8'h40] = 32'd100; mem[8'h41] = 32'd200;
    mem_rdata = 32'd0;
    rst = 1'b1; start = 1'b0; base_addr = 8'd0; count = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_sum", sum, 32'd0);
    check("rst_flags", {28'd0, overflow, busy, done, mem_re}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);

    do_run(8'h10, 8'd4, 32'd10, 1'b0, 1'b0);
    do_run(8'h10, 8'd0, 32'd0, 1'b0, 1'b0);
    do_run(8'hFE, 8'd3, 32'd6, 1'b1, 1'b0);

    // held start with arguments changed while busy; overflow from the last run must clear
    do_run(8'h40, 8'd2, 32'd300, 1'b0, 1'b1);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_done", {31'd0, done}, 32'd1);
      check("hold_sum", sum, 32'd300);
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("back_idle", {30'd0, busy, done}, 32'd0);

    // reset in the middle of a run
    launch(8'h10, 8'd4);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("reads_before_rst", exp_q.size(), 32'd2);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_sum", sum, 32'd0);
    check("midrst_flags", {29'd0, busy, done, mem_re}, 32'd0);
    exp_q.delete();
    do_run(8'h10, 8'd4, 32'd10, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
